// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the raster timing outputs of vga_timing_gen for the pixel/colour
// pipeline and the VGA connector.
//   pix_tick    : one-clk pulse per pixel period
//   x, y        : current pixel column / line, full range including blanking
//   di          : display enable, high inside the visible area
//   hsync/vsync : sync pulses at the configured polarity
//   line_start  : one-clk pulse when x changes to 0
//   frame_start : one-clk pulse when x changes to 0 on line 0
//   frame_cnt   : completed-frame counter, wraps 255 -> 0
// modport master : timing generator side (drives everything)
// modport slave  : consumer side (reads everything)
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic       pix_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       di;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output pix_tick, x, y, di, hsync, vsync, line_start, frame_start, frame_cnt
  );

  modport slave (
    input pix_tick, x, y, di, hsync, vsync, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator (640x480@60 Hz by default) running from the
// system clock with a clock-enable style pixel divider.
//   clk   : system clock
//   reset : asynchronous, active-high; clears all state immediately
//   vga   : vga_timing_gen_if.master, all timing outputs (all registered)
// Pipeline: div_cnt -> h_cnt/v_cnt (advance on the divider terminal count)
// -> registered decodes, loaded in the clk right after each counter update,
// so every decoded output is held for CLK_DIV clks.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [9:0]       h_cnt_q, h_cnt_d;
  logic [9:0]       v_cnt_q, v_cnt_d;
  logic             pix_tick_q, pix_tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             di_q, di_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             tick_s;

  // Pixel divider and raster counters: advance once per CLK_DIV clks.
  always_comb begin
    tick_s    = (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (tick_s) begin
      div_cnt_d = {DIV_W{1'b0}};
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = 10'd0;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Output decode: pix_tick_q marks the clk right after a counter update,
  // which is exactly when the registered decodes and strobes are loaded.
  always_comb begin
    pix_tick_d    = tick_s;
    x_d           = x_q;
    y_d           = y_q;
    di_d          = di_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_tick_q) begin
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      di_d          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      hsync_d       = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
      // h_cnt only sits at 0 after a wrap here; reset state never loads.
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      if ((h_cnt_q == 10'd0) && (v_cnt_q == 10'd0)) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      x_d = x_q;
    end
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q     <= {DIV_W{1'b0}};
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      pix_tick_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      di_q          <= 1'b0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_tick_q    <= pix_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      di_q          <= di_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga.pix_tick    = pix_tick_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.di          = di_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances on a shrunken raster (10 x 7 pixels) so that 256+ frames fit
// in a short run: dut_a with CLK_DIV=3 / active-low syncs, dut_b with
// CLK_DIV=1 / active-high syncs. Random asynchronous reset pulses are thrown
// in mid-frame. Expected outputs come from an arithmetic model indexed by the
// number of clk edges since reset release.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  localparam int HA = 6, HF = 1, HS = 2, HB = 1;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DA = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   k = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   run_chk = 1'b1;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  vga_timing_gen #(
    .CLK_DIV(DA), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
  ) dut_a (.clk(clk), .reset(reset), .vga(ifa));

  vga_timing_gen #(
    .CLK_DIV(DB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
  ) dut_b (.clk(clk), .reset(reset), .vga(ifb));

  always #5 clk = ~clk;

  logic [33:0] pack_a, pack_b;
  assign pack_a = {ifa.pix_tick, ifa.x, ifa.y, ifa.di, ifa.hsync, ifa.vsync,
                   ifa.line_start, ifa.frame_start, ifa.frame_cnt};
  assign pack_b = {ifb.pix_tick, ifb.x, ifb.y, ifb.di, ifb.hsync, ifb.vsync,
                   ifb.line_start, ifb.frame_start, ifb.frame_cnt};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after the e-th clk edge since reset release (e=0: reset).
  // The pixel counter steps on edges d, 2d, ...; outputs show it one edge later.
  function automatic logic [33:0] model(input int e, input int d, input bit pol);
    int n, xi, yi, fc;
    bit pt, ld, de, hs, vs, ls, fs;
    pt = (e >= 1) && (e % d == 0);
    if (e <= d) begin
      return {pt, 10'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 8'd0};
    end
    n  = (e - 1) / d;
    ld = ((e - 1) % d == 0);
    xi = n % HT;
    yi = (n / HT) % VT;
    de = (xi < HA) && (yi < VA);
    hs = (xi >= HA + HF && xi < HA + HF + HS) ? pol : ~pol;
    vs = (yi >= VA + VF && yi < VA + VF + VS) ? pol : ~pol;
    ls = ld && (xi == 0);
    fs = ls && (yi == 0);
    fc = (n / (HT * VT)) % 256;
    return {pt, 10'(xi), 10'(yi), de, hs, vs, ls, fs, 8'(fc)};
  endfunction

  // Edge count since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  int last_fs_a = -1, last_fs_b = -1, last_ls_a = -1, last_ls_b = -1;
  int wrap_a = 0, wrap_b = 0;
  logic [7:0] prev_fc_a = 8'd0, prev_fc_b = 8'd0;

  // Per-clk comparison against the model plus strobe spacing and wrap checks.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (run_chk) begin
      check("outputs_A", 64'(pack_a), 64'(model(reset ? 0 : k, DA, 1'b0)));
      check("outputs_B", 64'(pack_b), 64'(model(reset ? 0 : k, DB, 1'b1)));
      if (reset) begin
        last_fs_a = -1; last_fs_b = -1; last_ls_a = -1; last_ls_b = -1;
      end else begin
        if (ifa.frame_start) begin
          if (last_fs_a >= 0) check("fs_gap_A", 64'(cyc - last_fs_a), 64'(HT * VT * DA));
          last_fs_a = cyc;
          if (prev_fc_a == 8'd255) begin
            check("fc_wrap_A", 64'(ifa.frame_cnt), 64'd0);
            wrap_a++;
          end
        end
        if (ifb.frame_start) begin
          if (last_fs_b >= 0) check("fs_gap_B", 64'(cyc - last_fs_b), 64'(HT * VT * DB));
          last_fs_b = cyc;
          if (prev_fc_b == 8'd255) begin
            check("fc_wrap_B", 64'(ifb.frame_cnt), 64'd0);
            wrap_b++;
          end
        end
        if (ifa.line_start) begin
          if (last_ls_a >= 0) check("ls_gap_A", 64'(cyc - last_ls_a), 64'(HT * DA));
          last_ls_a = cyc;
        end
        if (ifb.line_start) begin
          if (last_ls_b >= 0) check("ls_gap_B", 64'(cyc - last_ls_b), 64'(HT * DB));
          last_ls_b = cyc;
        end
      end
      prev_fc_a = ifa.frame_cnt;
      prev_fc_b = ifb.frame_cnt;
    end
  end

  // Raise reset between edges and confirm outputs clear before the next edge.
  task automatic async_reset_pulse();
    int off;
    off = int'($urandom_range(1, 3));
    @(posedge clk);
    #(off);
    reset = 1'b1;
    #1;
    check("async_rst_A", 64'(pack_a), 64'(model(0, DA, 1'b0)));
    check("async_rst_B", 64'(pack_b), 64'(model(0, DB, 1'b1)));
    repeat (int'($urandom_range(1, 4))) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (int'($urandom_range(150, 500))) @(posedge clk);
    async_reset_pulse();
    repeat (int'($urandom_range(150, 500))) @(posedge clk);
    async_reset_pulse();
    // Long enough for dut_a to complete 257 frames and wrap frame_cnt.
    repeat (257 * HT * VT * DA + 50) @(posedge clk);
    @(negedge clk);
    #1;
    run_chk = 1'b0;
    check("wrap_seen_A", 64'(wrap_a >= 1), 64'd1);
    check("wrap_seen_B", 64'(wrap_b >= 1), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
